phase_seq_ctrl: RTL and testbench

Sequencer that owns and drives a WIDTH-bit shift counter. It runs the counter for a programmed number of steps in either Johnson (twisted-ring) or ring mode, then reports completion. It sits between a control master (start/stop/mode/steps) and downstream logic that consumes the phase vector `q`/`qbar` as multi-phase strobes.

---
 rtl/phase_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_phase_seq_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/phase_seq_ctrl.sv
// ---------------------------------------------------------------------------
// phase_seq_ctrl
//
// Sequencer that owns a WIDTH-bit shift counter and steps it a programmed
// number of times in Johnson (twisted-ring) or ring mode. Completion is
// reported with a one-cycle done pulse. Downstream logic uses q/qbar as
// multi-phase strobes.
//
// Optional feature macro: PHASE_SEQ_SELFCHECK_EN
//   defined   : q is checked for legality on every RUN edge; an illegal
//               code is replaced by the seed and the sticky err flag is set.
//   undefined : no checker, err tied low, illegal codes shift as-is.
//
// Parameters
//   WIDTH  counter width (>= 2)
//   CNT_W  width of the step count
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous reset, active low
//   start  in   run request (sampled in IDLE only)
//   stop   in   abort request (sampled in RUN only)
//   mode   in   0 = Johnson, 1 = ring (latched at start)
//   steps  in   number of shifts (latched at start)
//   q      out  phase vector (registered)
//   qbar   out  ~q
//   busy   out  high while running
//   done   out  one-cycle completion pulse
//   err    out  sticky illegal-state flag
// ---------------------------------------------------------------------------
module phase_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [CNT_W-1:0] steps,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [1:0]       state;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next_run;
  logic [CNT_W-1:0] remaining;
  logic             mode_l;

  // Johnson starts from all zeros, ring from a single set bit 0.
  function automatic logic [WIDTH-1:0] seed_of(input logic m);
    return {{(WIDTH-1){1'b0}}, m};
  endfunction

  // Johnson feeds back the inverted MSB, ring feeds back the MSB itself.
  function automatic logic [WIDTH-1:0] shift_of(input logic [WIDTH-1:0] v,
                                                input logic             m);
    return {v[WIDTH-2:0], (m ? v[WIDTH-1] : ~v[WIDTH-1])};
  endfunction

`ifdef PHASE_SEQ_SELFCHECK_EN
  // A legal Johnson code has at most one bit transition along its length
  // (exactly the 2*WIDTH codes of the cycle); a legal ring code is one-hot.
  function automatic logic is_legal(input logic [WIDTH-1:0] v,
                                    input logic             m);
    logic [WIDTH-2:0] edges;
    edges = v[WIDTH-1:1] ^ v[WIDTH-2:0];
    if (m)
      return (v != '0) && ((v & (v - 1'b1)) == '0);
    else
      return (edges & (edges - 1'b1)) == '0;
  endfunction

  logic legal;
  logic err_r;

  assign legal      = is_legal(q_r, mode_l);
  assign q_next_run = legal ? shift_of(q_r, mode_l) : seed_of(mode_l);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err_r <= 1'b0;
    else if (state == RUN && !legal)
      err_r <= 1'b1;
  end

  assign err = err_r;
`else
  assign q_next_run = shift_of(q_r, mode_l);
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      q_r       <= '0;
      remaining <= '0;
      mode_l    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_l    <= mode;
            q_r       <= seed_of(mode);
            remaining <= steps;
            state     <= (steps != CNT_ZERO) ? RUN : DONE;
          end
        end
        RUN: begin
          if (stop) begin
            // Abort freezes q on its current value.
            state <= DONE;
          end else begin
            q_r       <= q_next_run;
            remaining <= remaining - CNT_ONE;
            if (remaining == CNT_ONE)
              state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign q    = q_r;
  assign qbar = ~q_r;
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_phase_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_phase_seq_ctrl
//
// Directed and randomized runs of phase_seq_ctrl. Expected phase vectors are
// computed from the shift count with plain arithmetic (Johnson code k is a
// run of ones growing from bit 0, then shrinking from the bottom; ring code
// k is 1 << (k mod WIDTH)).
// Macro PHASE_SEQ_SELFCHECK_EN enables the illegal-state scenario.
// ---------------------------------------------------------------------------
module tb_phase_seq_ctrl;

  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk;
  logic          reset;
  logic          start;
  logic          stop;
  logic          mode;
  logic [CW-1:0] steps;
  logic [W-1:0]  q;
  logic [W-1:0]  qbar;
  logic          busy;
  logic          done;
  logic          err;

  int checks   = 0;
  int failures = 0;
  bit err_exp  = 1'b0;

  phase_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .stop  (stop),
    .mode  (mode),
    .steps (steps),
    .q     (q),
    .qbar  (qbar),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Phase vector after k shifts from the seed.
  function automatic logic [W-1:0] code(input bit m, input int k);
    int          j;
    logic [31:0] v;
    if (m) begin
      v = 32'd1 << (k % W);
    end else begin
      j = k % (2 * W);
      if (j <= W) v = (32'd1 << j) - 32'd1;
      else        v = ((32'd1 << W) - 32'd1) << (j - W);
    end
    return v[W-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] qe,
                           input bit be, input bit de);
    logic [W-1:0] qbe;
    qbe = ~qe;
    chk({tag, ".q"}, q, qe);
    chk({tag, ".qbar"}, qbar, qbe);
    chk({tag, ".busy_done_err"}, {busy, done, err}, {be, de, err_exp});
  endtask

  // One complete transaction: start, optional stop at RUN edge stop_at,
  // optional random start pulses during the run, then the return to IDLE.
  task automatic run(input bit m, input int n, input int stop_at,
                     input bit noise, input bit stop_with_start);
    int k;
    bit fin;
    k   = 0;
    fin = 1'b0;
    start = 1'b1; mode = m; steps = CW'(n); stop = stop_with_start;
    step();
    start = 1'b0; stop = 1'b0; mode = ~m; steps = CW'($urandom);
    check_out("seed", code(m, 0), n != 0, n == 0);
    if (n == 0) begin
      fin = 1'b1;
    end else begin
      for (int e = 1; e <= n + 1 && !fin; e++) begin
        stop = (e == stop_at);
        if (noise) start = 1'($urandom_range(0, 1));
        step();
        if (stop) begin
          check_out("stop", code(m, k), 1'b0, 1'b1);
          fin = 1'b1;
        end else begin
          k++;
          check_out("run", code(m, k), k < n, k == n);
          if (k == n) fin = 1'b1;
        end
        stop  = 1'b0;
        start = 1'b0;
      end
    end
    if (!fin) chk("run_bound", 32'(fin), 32'd1);
    step();
    check_out("idle", code(m, k), 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; steps = '0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", '0, 1'b0, 1'b0);
    reset = 1'b1;
    step();

    stop = 1'b1;
    step();
    check_out("idle_stop", '0, 1'b0, 1'b0);
    stop = 1'b0;

    run(1'b0, 8,   0, 1'b0, 1'b0);
    run(1'b1, 5,   0, 1'b0, 1'b0);
    run(1'b0, 20,  3, 1'b0, 1'b0);
    run(1'b0, 0,   0, 1'b0, 1'b0);
    run(1'b1, 0,   0, 1'b0, 1'b0);
    run(1'b0, 12,  0, 1'b1, 1'b0);
    run(1'b1, 7,   0, 1'b0, 1'b1);
    run(1'b1, 255, 0, 1'b0, 1'b0);

    repeat (25) begin
      int n;
      n = $urandom_range(0, 40);
      run(1'($urandom_range(0, 1)), n, $urandom_range(0, 45),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

`ifdef PHASE_SEQ_SELFCHECK_EN
    start = 1'b1; mode = 1'b0; steps = CW'(10);
    step();
    start = 1'b0;
    step();
    check_out("sc_pre", code(1'b0, 1), 1'b1, 1'b0);
    force dut.q_r = 4'b0101;
    #3;
    release dut.q_r;
    step();
    err_exp = 1'b1;
    check_out("sc_seed", 4'b0000, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step();
      check_out("sc_run", code(1'b0, i), i < 8, i == 8);
    end
    step();
    run(1'b1, 6, 0, 1'b0, 1'b0);
`endif

    start = 1'b1; mode = 1'b0; steps = CW'(10);
    step();
    start = 1'b0;
    step();
    step();
    check_out("pre_rst", code(1'b0, 2), 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    err_exp = 1'b0;
    #1;
    check_out("async_rst", '0, 1'b0, 1'b0);
    step();
    reset = 1'b1;
    step();
    check_out("post_rst", '0, 1'b0, 1'b0);
    run(1'b1, 6, 0, 1'b0, 1'b0);
    run(1'b0, 9, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
